// File: rtl/multicycle_mem_arbiter.sv
// Two-port round-robin arbiter that sequences one transaction at a time into a
// multicycle memory and completes bad opcodes and memory timeouts with an error.
module multicycle_mem_arbiter #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic [1:0]        a_op,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_done,
  output logic              a_err,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic [1:0]        b_op,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_done,
  output logic              b_err,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_start,
  output logic [1:0]        mem_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0]  OP_READ = 2'b01;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state, state_d;
  logic              ptr, ptr_d;
  logic              gnt, gnt_d;
  logic              sel_b;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              mem_start_d;
  logic [1:0]        mem_op_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              a_done_d, a_err_d, b_done_d, b_err_d;
  logic [DATA_W-1:0] a_rdata_d, b_rdata_d;
  logic              busy_d;

  // State, pointer and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      gnt       <= 1'b0;
      cnt       <= '0;
      mem_start <= 1'b0;
      mem_op    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_done    <= 1'b0;
      a_err     <= 1'b0;
      a_rdata   <= '0;
      b_done    <= 1'b0;
      b_err     <= 1'b0;
      b_rdata   <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      gnt       <= gnt_d;
      cnt       <= cnt_d;
      mem_start <= mem_start_d;
      mem_op    <= mem_op_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      a_done    <= a_done_d;
      a_err     <= a_err_d;
      a_rdata   <= a_rdata_d;
      b_done    <= b_done_d;
      b_err     <= b_err_d;
      b_rdata   <= b_rdata_d;
      busy      <= busy_d;
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    gnt_d       = gnt;
    cnt_d       = cnt;
    sel_b       = 1'b0;
    mem_start_d = 1'b0;
    mem_op_d    = mem_op;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    a_done_d    = 1'b0;
    a_err_d     = 1'b0;
    a_rdata_d   = a_rdata;
    b_done_d    = 1'b0;
    b_err_d     = 1'b0;
    b_rdata_d   = b_rdata;

    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          sel_b       = b_req && (!a_req || ptr);
          gnt_d       = sel_b;
          mem_op_d    = sel_b ? b_op    : a_op;
          mem_addr_d  = sel_b ? b_addr  : a_addr;
          mem_wdata_d = sel_b ? b_wdata : a_wdata;
          if (mem_op_d[1]) begin
            // Illegal op completes straight away without touching memory.
            state_d  = RESP;
            a_done_d = !sel_b;
            a_err_d  = !sel_b;
            b_done_d = sel_b;
            b_err_d  = sel_b;
          end else begin
            state_d     = ISSUE;
            mem_start_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_done) begin
          state_d  = RESP;
          a_done_d = !gnt;
          b_done_d = gnt;
          if (mem_op == OP_READ) begin
            if (gnt) b_rdata_d = mem_rdata;
            else     a_rdata_d = mem_rdata;
          end
        end else if (cnt == CNT_W'(TIMEOUT - 2)) begin
          // Counter would reach TIMEOUT-1 this cycle: abort with error.
          state_d  = RESP;
          a_done_d = !gnt;
          a_err_d  = !gnt;
          b_done_d = gnt;
          b_err_d  = gnt;
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = !gnt;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_multicycle_mem_arbiter.sv
// Scoreboard bench for multicycle_mem_arbiter: two requester drivers, a
// behavioural memory with per-transaction latency, and a completion monitor.
module tb_multicycle_mem_arbiter;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int          TO      = TIMEOUT;

  typedef struct {
    logic              legal;
    logic              err;
    logic [DATA_W-1:0] rdata;
    int                lat;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        req;
  logic [1:0]        opv   [2];
  logic [ADDR_W-1:0] addrv [2];
  logic [DATA_W-1:0] wdv   [2];
  int                latv  [2];
  logic              a_done, a_err, b_done, b_err;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic              mem_start, mem_done, busy;
  logic [1:0]        mem_op;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  logic [1:0]        dn;
  logic [1:0]        ev;
  logic [DATA_W-1:0] rdv [2];

  assign dn     = {b_done, a_done};
  assign ev     = {b_err, a_err};
  assign rdv[0] = a_rdata;
  assign rdv[1] = b_rdata;

  int   n_checks = 0, n_err = 0, cyc = 0;
  int   n_starts = 0, exp_starts = 0, start_cyc = 0, exp_ptr = 0;
  exp_t q0[$], q1[$];
  int   grant_log[$];
  logic [DATA_W-1:0] shadow [256];
  logic [DATA_W-1:0] mem_arr [256];
  logic [DATA_W-1:0] pred_rd [2];
  logic [DATA_W-1:0] last_seen [2];

  multicycle_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .a_req(req[0]), .a_op(opv[0]), .a_addr(addrv[0]), .a_wdata(wdv[0]),
    .a_done(a_done), .a_err(a_err), .a_rdata(a_rdata),
    .b_req(req[1]), .b_op(opv[1]), .b_addr(addrv[1]), .b_wdata(wdv[1]),
    .b_done(b_done), .b_err(b_err), .b_rdata(b_rdata),
    .mem_start(mem_start), .mem_op(mem_op), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one transaction on port p and wait for its completion; caller is 1ns after an edge.
  task automatic do_txn(input int p, input logic [1:0] op, input int addr, input int wd,
                        input int lat, output int took);
    exp_t e;
    int   t0;
    bit   got;
    e.legal = (op[1] == 1'b0);
    e.lat   = lat;
    e.err   = !e.legal || lat < 0 || lat > TO - 2;
    if (e.legal && lat >= 0 && op == 2'b00) shadow[addr] = DATA_W'(wd);
    if (!e.err && op == 2'b01) pred_rd[p] = shadow[addr];
    e.rdata = pred_rd[p];
    if (p == 0) q0.push_back(e); else q1.push_back(e);
    opv[p]   = op;
    addrv[p] = ADDR_W'(addr);
    wdv[p]   = DATA_W'(wd);
    latv[p]  = lat;
    req[p]   = 1'b1;
    t0  = cyc;
    got = 1'b0;
    for (int i = 0; i < 4 * TO + 40 && !got; i++) begin
      @(posedge clk); #1;
      if (dn[p]) got = 1'b1;
    end
    chk($sformatf("done_seen_p%0d", p), 32'(got), 1);
    took   = cyc - t0;
    req[p] = 1'b0;
  endtask

  task automatic rand_txn(input int p);
    logic [1:0] op;
    int r, lat, took;
    r  = $urandom_range(0, 9);
    op = (r == 0) ? 2'($urandom_range(2, 3)) : (r < 5) ? 2'b00 : 2'b01;
    r  = $urandom_range(0, 19);
    lat = (r == 0) ? -1 : (r == 1) ? TO - 2 : (r == 2) ? TO - 1 : $urandom_range(0, 4);
    do_txn(p, op, 2 * $urandom_range(0, 7) + p, $urandom_range(0, 255), lat, took);
  endtask

  task automatic check_pair(input int base, input int first);
    if (grant_log.size() < base + 2) chk("pair_log_len", grant_log.size(), base + 2);
    else begin
      chk("pair_first", grant_log[base], first);
      chk("pair_second", grant_log[base + 1], 1 - first);
    end
  endtask

  // Behavioural memory: latency chosen by the requester that owns the transaction.
  initial begin : memory_model
    int p, lat;
    logic [1:0] op;
    logic [ADDR_W-1:0] ad;
    logic [DATA_W-1:0] wd;
    mem_done  = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_done  = 1'b0;
      mem_rdata = DATA_W'($urandom);
      if (rst && mem_start) begin
        n_starts++;
        start_cyc = cyc;
        op = mem_op; ad = mem_addr; wd = mem_wdata;
        p = -1;
        for (int i = 1; i >= 0; i--)
          if (req[i] && opv[i] == op && addrv[i] == ad && wdv[i] == wd) p = i;
        chk("mem_start_matches_req", 32'(p >= 0), 1);
        lat = (p >= 0) ? latv[p] : -1;
        if (lat >= 0) begin
          @(posedge clk); #1;
          chk("mem_start_one_cycle", 32'(mem_start), 0);
          repeat (lat) begin
            @(posedge clk); #1;
            mem_rdata = DATA_W'($urandom);
          end
          if (rst) begin
            chk("mem_bus_stable", {mem_op, mem_addr, mem_wdata}, {op, ad, wd});
            mem_done  = 1'b1;
            mem_rdata = (op == 2'b01) ? mem_arr[ad] : DATA_W'($urandom);
            if (op == 2'b00) mem_arr[ad] = wd;
          end
        end
      end else if (rst && !busy && $urandom_range(0, 3) == 0) begin
        mem_done = 1'b1;
      end
    end
  end

  // Completion monitor: pops the requester's expectation on every done pulse.
  initial begin : monitor
    exp_t e;
    int   exp_lat;
    forever begin
      @(posedge clk); #1;
      if (rst && (a_done || b_done)) begin
        chk("exclusive_done", 32'(a_done && b_done), 0);
        for (int p = 0; p < 2; p++) begin
          if (dn[p]) begin
            if ((p == 0 ? q0.size() : q1.size()) == 0)
              chk($sformatf("unexpected_done_p%0d", p), 0, 1);
            else begin
              e = (p == 0) ? q0.pop_front() : q1.pop_front();
              chk($sformatf("err_p%0d", p), 32'(ev[p]), 32'(e.err));
              chk($sformatf("rdata_p%0d", p), 32'(rdv[p]), 32'(e.rdata));
              chk($sformatf("hold_rdata_p%0d", 1 - p), 32'(rdv[1 - p]), 32'(last_seen[1 - p]));
              last_seen[p] = e.rdata;
              grant_log.push_back(p);
              exp_ptr = 1 - p;
              if (e.legal) begin
                exp_starts++;
                chk("start_count", n_starts, exp_starts);
                exp_lat = (e.lat < 0 || e.lat > TO - 2) ? TO : e.lat + 2;
                chk("start_to_done", cyc - start_cyc, exp_lat);
              end
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int took, base, s0, first;
    bit got;
    rst = 1'b0;
    req = '0;
    for (int i = 0; i < 2; i++) begin
      opv[i] = '0; addrv[i] = '0; wdv[i] = '0; latv[i] = 0;
      pred_rd[i] = '0; last_seen[i] = '0;
    end
    for (int i = 0; i < 256; i++) begin
      mem_arr[i] = DATA_W'($urandom);
      shadow[i]  = mem_arr[i];
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_bus", {mem_start, mem_op, mem_addr, mem_wdata}, 0);
    chk("rst_a_out", {a_done, a_err, a_rdata}, 0);
    chk("rst_b_out", {b_done, b_err, b_rdata}, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Simultaneous pair after reset: A first.
    base = grant_log.size();
    fork
      do_txn(0, 2'b00, 20, 8'h11, 1, took);
      do_txn(1, 2'b00, 21, 8'h22, 0, took);
    join
    @(posedge clk); #1;
    check_pair(base, 0);

    // Lone A write at minimum latency, then a pair served B first.
    do_txn(0, 2'b00, 10, 42, 0, took);
    chk("min_latency", took, 3);
    base = grant_log.size();
    fork
      do_txn(0, 2'b01, 10, 0, 1, took);
      do_txn(1, 2'b01, 21, 0, 2, took);
    join
    @(posedge clk); #1;
    check_pair(base, 1);
    chk("a_read_back", 32'(a_rdata), 42);
    chk("b_read_back", 32'(b_rdata), 32'h22);

    // Illegal op on B: immediate error completion, memory untouched.
    s0 = n_starts;
    do_txn(1, 2'b11, 5, 0, 0, took);
    chk("illegal_latency", took, 1);
    chk("illegal_no_start", n_starts, s0);
    base = grant_log.size();
    fork
      do_txn(0, 2'b01, 10, 0, 0, took);
      do_txn(1, 2'b00, 7, 8'h33, 0, took);
    join
    @(posedge clk); #1;
    check_pair(base, 0);

    // Timeout on A, then a normal B request; then both sides of the timeout boundary.
    do_txn(0, 2'b01, 3, 0, -1, took);
    chk("timeout_a_rdata_held", 32'(a_rdata), 42);
    do_txn(1, 2'b01, 7, 0, 1, took);
    do_txn(0, 2'b01, 10, 0, TO - 2, took);
    do_txn(0, 2'b01, 20, 0, TO - 1, took);
    do_txn(0, 2'b01, 20, 0, 0, took);

    // Both ports requesting continuously: strict alternation.
    base  = grant_log.size();
    first = exp_ptr;
    fork
      repeat (16) rand_txn(0);
      repeat (16) rand_txn(1);
    join
    chk("busy_at_final_done", 32'(busy), 1);
    @(posedge clk); #1;
    chk("busy_after_final_done", 32'(busy), 0);
    chk("b2b_log_len", grant_log.size(), base + 32);
    if (grant_log.size() == base + 32) begin
      chk("b2b_first", grant_log[base], first);
      for (int i = base + 1; i < base + 32; i++)
        chk("b2b_alternate", 32'(grant_log[i] != grant_log[i - 1]), 1);
    end

    // Randomly spaced requests.
    fork
      repeat (12) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rand_txn(0);
      end
      repeat (12) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        rand_txn(1);
      end
    join

    // Reset while A is waiting on a silent memory.
    req[0] = 1'b1; opv[0] = 2'b01; addrv[0] = 8'd40; wdv[0] = '0; latv[0] = -1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(posedge clk); #1;
      if (mem_start) got = 1'b1;
    end
    chk("rst_test_started", 32'(got), 1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("midrst_mem_bus", {mem_start, mem_op, mem_addr, mem_wdata}, 0);
    chk("midrst_done", {a_done, b_done}, 0);
    chk("midrst_busy", 32'(busy), 0);
    req[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin pred_rd[i] = '0; last_seen[i] = '0; end
    n_starts = 0; exp_starts = 0; exp_ptr = 0;
    repeat (2) @(posedge clk);
    chk("midrst_a_rdata", 32'(a_rdata), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    do_txn(0, 2'b00, 10, 8'h5A, 0, took);
    chk("post_rst_latency", took, 3);
    do_txn(0, 2'b01, 10, 0, 2, took);

    repeat (4) @(posedge clk);
    #1;
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
